// File: rtl/alu_seq.sv
// Handshaked ALU with registered result, shifts and optional iterative multiply.
// Latency 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL (ALU_SEQ_MUL_EN).
// Holds the result in DONE until out_ready; in_ready only while IDLE (one op in flight).
//
// Ports: clk/rst (async, active-high); in_valid/in_ready/op/in_x/in_y request side;
//        out_valid/out_ready/out_s/out_c/zero/overflow/err result side.
// Build option: define ALU_SEQ_MUL_EN to enable op 1011 as a shift-add multiplier;
//        without it op 1011 behaves as a reserved opcode (err=1, latency 1).
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_c,
    output logic             zero,
    output logic             overflow,
    output logic             err
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_NOT = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SLT = 4'b0110;
    localparam logic [3:0] OP_SEQ = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1011;
    localparam int         SHW    = $clog2(WIDTH);
`endif

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             z;
        logic             v;
        logic             e;
    } res_t;

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
    typedef enum logic {IDLE = 1'b0, DONE = 1'b1} state_t;
`endif

    state_t state, state_n;
    logic   accept;
    res_t   res;

    // Arithmetic and shift helpers, all from the live request inputs: single-cycle
    // results are captured directly into the output registers on accept.
    logic [WIDTH:0] add_w, sub_w, sll_w, srl_w, sra_w;
    logic           add_ovf, sub_ovf, slt_bit, eq, shift_big, shift_zero;

    assign add_w   = {1'b0, in_x} + {1'b0, in_y};
    assign sub_w   = {1'b0, in_x} + {1'b0, ~in_y} + {{WIDTH{1'b0}}, 1'b1};
    assign add_ovf = (in_x[WIDTH-1] == in_y[WIDTH-1]) && (add_w[WIDTH-1] != in_x[WIDTH-1]);
    assign sub_ovf = (in_x[WIDTH-1] != in_y[WIDTH-1]) && (sub_w[WIDTH-1] != in_x[WIDTH-1]);
    assign slt_bit = sub_w[WIDTH-1] ^ sub_ovf;
    assign eq      = (in_x == in_y);

    // One guard bit beside the operand catches the last bit shifted out.
    assign sll_w      = {1'b0, in_x} << in_y;
    assign srl_w      = {in_x, 1'b0} >> in_y;
    assign sra_w      = $unsigned($signed({in_x, 1'b0}) >>> in_y);
    assign shift_big  = (in_y >= WIDTH'(WIDTH));
    assign shift_zero = (in_y == '0);

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        res = '0;
        unique case (op)
            OP_ADD: begin
                res.s = add_w[WIDTH-1:0];
                res.c = add_w[WIDTH];
                res.v = add_ovf;
                res.z = ~|add_w[WIDTH-1:0];
            end
            OP_SUB: begin
                res.s = sub_w[WIDTH-1:0];
                res.c = sub_w[WIDTH];
                res.v = sub_ovf;
                res.z = ~|sub_w[WIDTH-1:0];
            end
            OP_NOT: begin
                res.s = ~in_x;
                res.z = ~|res.s;
            end
            OP_AND: begin
                res.s = in_x & in_y;
                res.z = ~|res.s;
            end
            OP_OR: begin
                res.s = in_x | in_y;
                res.z = ~|res.s;
            end
            OP_XOR: begin
                res.s = in_x ^ in_y;
                res.z = ~|res.s;
            end
            OP_SLT: begin
                res.s = {{(WIDTH-1){1'b0}}, slt_bit};
                res.z = eq;
            end
            OP_SEQ: begin
                res.s = {{(WIDTH-1){1'b0}}, eq};
                res.z = eq;
            end
            OP_SLL: begin
                if (shift_zero) begin
                    res.s = in_x;
                end else if (!shift_big) begin
                    res.s = sll_w[WIDTH-1:0];
                    res.c = sll_w[WIDTH];
                end
                res.z = ~|res.s;
            end
            OP_SRL: begin
                if (shift_zero) begin
                    res.s = in_x;
                end else if (!shift_big) begin
                    res.s = srl_w[WIDTH:1];
                    res.c = srl_w[0];
                end
                res.z = ~|res.s;
            end
            OP_SRA: begin
                if (shift_zero) begin
                    res.s = in_x;
                end else if (shift_big) begin
                    res.s = {WIDTH{in_x[WIDTH-1]}};
                end else begin
                    res.s = sra_w[WIDTH:1];
                    res.c = sra_w[0];
                end
                res.z = ~|res.s;
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: res = '0;  // produced by the BUSY datapath instead
`endif
            default: res.e = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    // Shift-add multiplier: one partial product of the latched operands per BUSY cycle.
    logic [WIDTH-1:0]   x_r, y_r;
    logic [2*WIDTH-1:0] prod, prod_n;
    logic [SHW-1:0]     count;
    logic               mul_last;

    assign mul_last = (count == SHW'(WIDTH - 1));
    assign prod_n   = prod + (y_r[count] ? ({{WIDTH{1'b0}}, x_r} << count) : '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                    state_n = (op == OP_MUL) ? BUSY : DONE;
`else
                    state_n = DONE;
`endif
                end
            end
`ifdef ALU_SEQ_MUL_EN
            BUSY: if (mul_last) state_n = DONE;
`endif
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_s    <= '0;
            out_c    <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            err      <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            x_r      <= '0;
            y_r      <= '0;
            prod     <= '0;
            count    <= '0;
`endif
        end else if (accept) begin
`ifdef ALU_SEQ_MUL_EN
            if (op == OP_MUL) begin
                x_r   <= in_x;
                y_r   <= in_y;
                prod  <= '0;
                count <= '0;
            end else
`endif
            begin
                out_s    <= res.s;
                out_c    <= res.c;
                zero     <= res.z;
                overflow <= res.v;
                err      <= res.e;
            end
        end
`ifdef ALU_SEQ_MUL_EN
        else if (state == BUSY) begin
            prod  <= prod_n;
            count <= count + 1'b1;
            if (mul_last) begin
                out_s    <= prod_n[WIDTH-1:0];
                out_c    <= 1'b0;
                zero     <= ~|prod_n[WIDTH-1:0];
                overflow <= |prod_n[2*WIDTH-1:WIDTH];
                err      <= 1'b0;
            end
        end
`endif
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=4 with hand-computed expected results.
// Latency checked at fixed cycle offsets from accept; no open-ended waits.
// Backpressure exercised by holding out_ready low while a new request is offered.
module tb_alu_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] in_x, in_y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_s;
    logic         out_c, zero, overflow, err;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in_x      (in_x),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_c     (out_c),
        .zero      (zero),
        .overflow  (overflow),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Presents a request at a falling edge; returns at the falling edge one cycle after accept.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        in_valid = 1'b1;
        op       = o;
        in_x     = x;
        in_y     = y;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_res(input string tag, input logic [W-1:0] s, input logic c,
                              input logic z, input logic v, input logic e);
        chk1({tag, ".valid"}, out_valid, 1'b1);
        chkn({tag, ".s"}, out_s, s);
        chk1({tag, ".c"}, out_c, c);
        chk1({tag, ".zero"}, zero, z);
        chk1({tag, ".ovf"}, overflow, v);
        chk1({tag, ".err"}, err, e);
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk1({tag, ".ret_valid"}, out_valid, 1'b0);
        chk1({tag, ".ret_ready"}, in_ready, 1'b1);
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] s, input logic c,
                          input logic z, input logic v, input logic e);
        issue(o, x, y);
        expect_res(tag, s, c, z, v, e);
        retire(tag);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = 4'd0;
        in_x      = '0;
        in_y      = '0;
        out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        chk1("rst.in_ready", in_ready, 1'b0);
        chk1("rst.out_valid", out_valid, 1'b0);
        chkn("rst.s", out_s, 4'h0);
        chk1("rst.c", out_c, 1'b0);
        chk1("rst.zero", zero, 1'b0);
        chk1("rst.ovf", overflow, 1'b0);
        chk1("rst.err", err, 1'b0);
        rst = 1'b0;
        #1;
        chk1("rst.release_ready", in_ready, 1'b1);
        @(negedge clk);

        //      tag         op     x      y      s      c     z     v     e
        run_op("add_ovf",  4'h0, 4'h7, 4'h1, 4'h8, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("add_wrap", 4'h0, 4'hF, 4'h1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op("sub_eq",   4'h1, 4'h3, 4'h3, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op("sub_brw",  4'h1, 4'h0, 4'h1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("sub_ovf",  4'h1, 4'h8, 4'h1, 4'h7, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op("not",      4'h2, 4'h5, 4'h0, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("and",      4'h3, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("or",       4'h4, 4'hC, 4'h3, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("xor",      4'h5, 4'h5, 4'h5, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("slt_ovf",  4'h6, 4'h8, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("slt_neg",  4'h6, 4'h2, 4'h5, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("slt_eq",   4'h6, 4'h5, 4'h5, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("seq",      4'h7, 4'h6, 4'h6, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("sra_1",    4'hA, 4'h8, 4'h1, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("sra_4",    4'hA, 4'h8, 4'h4, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("sra_pos7", 4'hA, 4'h4, 4'h7, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("sra_0",    4'hA, 4'h9, 4'h0, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("sll_5",    4'h8, 4'h9, 4'h5, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("sll_1",    4'h8, 4'h9, 4'h1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("srl_1",    4'h9, 4'h3, 4'h1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("rsv_e",    4'hE, 4'h7, 4'h7, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("rsv_f",    4'hF, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Backpressure: result held while a competing request is offered
        issue(4'h0, 4'h2, 4'h3);
        expect_res("hold", 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        op       = 4'h0;
        in_x     = 4'h1;
        in_y     = 4'h1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("hold.valid", out_valid, 1'b1);
            chkn("hold.s", out_s, 4'h5);
            chk1("hold.zero", zero, 1'b0);
            chk1("hold.in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        retire("hold");

`ifdef ALU_SEQ_MUL_EN
        // Multiplier: busy T+1..T+4, result at T+5
        issue(4'hB, 4'h5, 4'h3);
        for (int i = 1; i <= 4; i++) begin
            chk1("mul.busy_valid", out_valid, 1'b0);
            chk1("mul.busy_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        expect_res("mul_5x3", 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        chk1("mul.done_ready", in_ready, 1'b0);
        retire("mul_5x3");

        issue(4'hB, 4'h4, 4'h4);
        repeat (4) @(negedge clk);
        expect_res("mul_4x4", 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        retire("mul_4x4");

        issue(4'hB, 4'hF, 4'hF);
        repeat (4) @(negedge clk);
        expect_res("mul_fxf", 4'h1, 1'b0, 1'b0, 1'b1, 1'b0);
        retire("mul_fxf");

        // Reset while BUSY aborts the multiply
        issue(4'hB, 4'h3, 4'h3);
        @(negedge clk);
        rst = 1'b1;
        #1;
`else
        run_op("mul_off",  4'hB, 4'h5, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset while DONE discards a result with non-zero flags
        issue(4'h0, 4'hF, 4'h1);
        expect_res("pre_rst", 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
`endif
        chk1("abort.valid", out_valid, 1'b0);
        chkn("abort.s", out_s, 4'h0);
        chk1("abort.c", out_c, 1'b0);
        chk1("abort.zero", zero, 1'b0);
        chk1("abort.ovf", overflow, 1'b0);
        chk1("abort.err", err, 1'b0);
        chk1("abort.in_ready", in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("abort.release_ready", in_ready, 1'b1);
        repeat (6) @(negedge clk);
        chk1("abort.no_result", out_valid, 1'b0);

        // Normal operation after the abort
        run_op("post_rst", 4'h0, 4'h3, 4'h4, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
